seq_adder: RTL and testbench
============================

// Module: seq_adder
// PURPOSE
//   Multi-cycle, digit-serial two's-complement adder: the add-direction counterpart of the combinational subtractor.
//   Adds DIGIT bits per clock, LSB digit first, through one DIGIT-bit carry chain. Flags signed overflow and unsigned carry-out.
//   Sits in the ALU datapath where area matters more than latency.
//   Uses a start/busy/done handshake with a controller or testbench.
// PARAMETERS
//   WIDTH  32  operand/result width in bits
//   DIGIT  4   bits added per cycle; WIDTH % DIGIT == 0 required (8 digit-cycles at defaults)
// PORTS
//   clk       in   1      rising-edge clock
//   rst       in   1      asynchronous, active-high reset
//   start     in   1      request; accepted only in IDLE or DONE
//   a         in   WIDTH  operand A, sampled on the accepting edge
//   b         in   WIDTH  operand B, sampled on the accepting edge
//   busy      out  1      high while in RUN
//   done      out  1      one-cycle pulse; result valid
//   sum       out  WIDTH  a + b mod 2^WIDTH; held until next accept
//   carry     out  1      unsigned carry out of MSB
//   overflow  out  1      signed overflow: carry into MSB XOR carry out of MSB
// BEHAVIOUR
//   - Reset (async assert, sync release): state=IDLE; busy=0, done=0, sum=0, carry=0, overflow=0. Internal regs and digit counter=0.
//   - FSM states: IDLE -> RUN on start; RUN -> DONE when last digit is added; DONE -> IDLE next cycle, or RUN if start=1.
//   - Accept edge: latch a and b into shift registers; clear carry-in to 0; counter=0; busy=1 from the next cycle.
//   - RUN, each cycle: add the low DIGIT bits of A and B plus the carry reg.
//     Shift the DIGIT-bit result into the sum register from the MSB side; shift the operands right by DIGIT; counter++.
//   - Last digit (counter == WIDTH/DIGIT-1): capture carry-out and overflow.
//     Overflow = c_in(MSB) ^ c_out(MSB), taken from the final digit's internal chain.
//   - Latency: start accepted at edge N; done=1 during cycle N+WIDTH/DIGIT+1; sum/carry/overflow valid from that cycle.
//   - start while busy=1: ignored, no queuing; operands are not re-sampled.
//   - start while done=1: accepted (back-to-back); done still pulses only one cycle.
//   - sum/carry/overflow are updated only on the final digit edge.
//     They are never shown partial; they hold the old result during RUN.
//   - done never asserts together with busy.
//   - Reset mid-RUN: abort immediately; all outputs go to reset values; no done pulse.
//   - Wrap-around: sum is always modulo 2^WIDTH. carry and overflow are independent flags; both may be 1.
// TESTING
//   1. a=32'h104A904A, b=32'h504A904F -> sum=32'h60952099, carry=0, overflow=0; done exactly 9 cycles after start.
//   2. a=32'h7FFFFFFF, b=32'h00000001 -> sum=32'h80000000, carry=0, overflow=1.
//   3. a=32'h80000000, b=32'h80000000 -> sum=32'h00000000, carry=1, overflow=1.
//   4. a=32'hFFFFFDF8, b=32'h00000208 -> sum=32'h00000000, carry=1, overflow=0.
//   5. Pulse start again at RUN cycle 3 with other operands -> ignored; result is the first operation's.
//      Then start in the done cycle -> second result follows after 9 more cycles.
//   6. Assert rst at RUN cycle 4 -> busy, done, sum, carry, overflow all 0 at once.
//      After release, a fresh start completes correctly.

Source files
------------

// File: rtl/seq_adder_if.sv
// ---------------------------------------------------------------------------
// seq_adder_if
//   Bundles the start/busy/done handshake and the operand/result bus of the
//   digit-serial adder.
//
//   Handshake: the master raises start with a and b valid. The slave accepts
//   the request on a rising edge only when it is idle or showing done. It
//   signals acceptance by raising busy from the next cycle onward. A start
//   seen while busy is dropped and is not queued. When done pulses for one
//   cycle, sum/carry/overflow are valid, and they hold until the next accept
//   completes. busy and done are never high together.
//
//   Signals
//     start     master -> slave  request
//     a, b      master -> slave  operands (WIDTH bits), sampled on accept
//     busy      slave -> master  operation in progress
//     done      slave -> master  one-cycle completion pulse
//     sum       slave -> master  a + b mod 2^WIDTH
//     carry     slave -> master  unsigned carry out of the MSB
//     overflow  slave -> master  signed overflow
// ---------------------------------------------------------------------------
interface seq_adder_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             overflow;

  modport master (
    output start, a, b,
    input  busy, done, sum, carry, overflow
  );

  modport slave (
    input  start, a, b,
    output busy, done, sum, carry, overflow
  );
endinterface

// File: rtl/seq_adder.sv
// ---------------------------------------------------------------------------
// seq_adder
//   Digit-serial two's-complement adder. It adds DIGIT bits per clock, starting
//   with the LSB digit, through a single DIGIT-bit carry chain. It needs
//   WIDTH/DIGIT cycles per add. It reports the unsigned carry-out and the
//   signed overflow of the full-width result.
//
//   Ports
//     clk      rising-edge clock
//     rst      asynchronous, active-high reset (released synchronously)
//     bus_io   seq_adder_if.slave: start, a, b in; busy, done, sum, carry,
//              overflow out
//     state_o  current FSM state (0 = IDLE, 1 = RUN, 2 = DONE)
//
//   Timing
//     The request is accepted at edge N, and busy is high from the cycle after
//     N. The last digit is added at edge N+WIDTH/DIGIT. In the cycle that
//     follows, done pulses and the new sum/carry/overflow become visible. The
//     outputs change only on that final-digit edge, so a partially built sum is
//     never visible.
// ---------------------------------------------------------------------------
module seq_adder #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  seq_adder_if.slave  bus_io,
  output logic [1:0]  state_o
);

  localparam int NDIG  = WIDTH / DIGIT;
  localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CNT_W-1:0] LAST_DIG = CNT_W'(NDIG - 1);

  // The slicing below assumes at least two digits and whole digits only.
  if ((WIDTH % DIGIT) != 0) begin : g_bad_digit
    $error("seq_adder: WIDTH must be a multiple of DIGIT");
  end
  if (NDIG < 2) begin : g_bad_ndig
    $error("seq_adder: WIDTH must hold at least two digits");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_t           state_q;
  logic [WIDTH-1:0] a_q;       // operand A, shifted right one digit per cycle
  logic [WIDTH-1:0] b_q;       // operand B, shifted right one digit per cycle
  logic [WIDTH-1:0] acc_q;     // partial sum, filled from the MSB side
  logic             cin_q;     // carry between digits
  logic [CNT_W-1:0] cnt_q;     // index of the digit being added
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] sum_q;     // visible result, written only on the last digit
  logic             carry_q;
  logic             ovf_q;

  // -------------------------------------------------------------------------
  // One DIGIT-bit carry chain working on the low digit of the operand shifters
  // -------------------------------------------------------------------------
  logic [DIGIT:0]   dig_full_d;
  logic [DIGIT-1:0] dig_sum_d;
  logic             dig_cout_d;
  logic             dig_cmsb_d;
  logic [WIDTH-1:0] acc_d;
  logic [WIDTH-1:0] a_d;
  logic [WIDTH-1:0] b_d;
  logic             last_d;

  always_comb begin
    dig_full_d = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]}
               + {{DIGIT{1'b0}}, cin_q};
    dig_sum_d  = dig_full_d[DIGIT-1:0];
    dig_cout_d = dig_full_d[DIGIT];
    // The top bit of the digit sum is a ^ b ^ c_in at that position, so the
    // carry into the top bit can be recovered from the digit sum.
    dig_cmsb_d = a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ dig_sum_d[DIGIT-1];
    // The new digit enters at the MSB end. After NDIG shifts, the first digit
    // has reached bit 0.
    acc_d      = {dig_sum_d, acc_q[WIDTH-1:DIGIT]};
    a_d        = {{DIGIT{1'b0}}, a_q[WIDTH-1:DIGIT]};
    b_d        = {{DIGIT{1'b0}}, b_q[WIDTH-1:DIGIT]};
    last_d     = (cnt_q == LAST_DIG);
  end

  // -------------------------------------------------------------------------
  // Controller and datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cin_q   <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (bus_io.start) begin
            a_q     <= bus_io.a;
            b_q     <= bus_io.b;
            acc_q   <= '0;
            cin_q   <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_RUN;
          end
        end

        // While in this state, start is ignored and the operands are not
        // sampled again.
        ST_RUN: begin
          a_q   <= a_d;
          b_q   <= b_d;
          acc_q <= acc_d;
          cin_q <= dig_cout_d;
          if (last_d) begin
            cnt_q   <= '0;
            sum_q   <= acc_d;
            carry_q <= dig_cout_d;
            ovf_q   <= dig_cmsb_d ^ dig_cout_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        // Allows back-to-back operation: a start here begins the next add
        // right away, and done still drops after one cycle.
        ST_DONE: begin
          done_q <= 1'b0;
          if (bus_io.start) begin
            a_q     <= bus_io.a;
            b_q     <= bus_io.b;
            acc_q   <= '0;
            cin_q   <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_RUN;
          end else begin
            state_q <= ST_IDLE;
          end
        end

        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Outputs (all registered)
  // -------------------------------------------------------------------------
  assign bus_io.busy     = busy_q;
  assign bus_io.done     = done_q;
  assign bus_io.sum      = sum_q;
  assign bus_io.carry    = carry_q;
  assign bus_io.overflow = ovf_q;
  assign state_o         = state_q;

endmodule

// File: tb/tb_seq_adder.sv
// ---------------------------------------------------------------------------
// tb_seq_adder
//   Directed bench for seq_adder. A reference adder written in plain arithmetic
//   feeds an expected queue. A compare process checks the visible result every
//   cycle against the value the last completed request must have produced.
//   Directed vectors also check hand-computed literals and latency.
// ---------------------------------------------------------------------------
module tb_seq_adder;

  localparam int W = 32;

  logic       clk;
  logic       rst;
  logic [1:0] state_o;

  seq_adder_if #(.WIDTH(W)) bus ();

  seq_adder #(.WIDTH(W), .DIGIT(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus_io  (bus),
    .state_o (state_o)
  );

  // ---------------- clock / reset -----------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bookkeeping -------------------------------------------
  int checks   = 0;
  int failures = 0;

  // Each entry is {overflow, carry, sum}.
  logic [W+1:0] exp_q[$];
  logic [W+1:0] held;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Reference: full-precision add. Signed overflow occurs when the operands
  // share a sign and the result's sign differs from it.
  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W:0] s;
    logic       v;
    s = {1'b0, x} + {1'b0, y};
    v = (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
    return {v, s[W], s[W-1:0]};
  endfunction

  // ---------------- scoreboard / compare process ---------------------------
  logic prev_done;
  initial begin
    held      = '0;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        held      = '0;
        prev_done = 1'b0;
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
      end else begin
        if (bus.busy && bus.done) chk("busy_with_done", 64'd1, 64'd0);
        if (bus.done && prev_done) chk("done_single_pulse", 64'd1, 64'd0);
        if (bus.done) begin
          if (exp_q.size() == 0) chk("done_unexpected", 64'd1, 64'd0);
          else held = exp_q.pop_front();
        end
        prev_done = bus.done;
      end
      chk("result_vs_model", 64'({bus.overflow, bus.carry, bus.sum}), 64'(held));
    end
  end

  // ---------------- driver tasks ------------------------------------------
  // Waits for done, one clock at a time, and returns the number of rising
  // edges seen. start is dropped after the first edge.
  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
      bus.start = 1'b0;
      if (!bus.done) chk("busy_in_run", 64'(bus.busy), 64'd1);
    end while (!bus.done && n < 40);
    if (!bus.done) chk("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv);
    bus.a     = av;
    bus.b     = bv;
    bus.start = 1'b1;
    exp_q.push_back(model(av, bv));
  endtask

  task automatic check_result(input string nm, input logic [W-1:0] es,
                              input logic ec, input logic eo);
    chk({nm, "_sum"},  64'(bus.sum),      64'(es));
    chk({nm, "_carry"}, 64'(bus.carry),    64'(ec));
    chk({nm, "_ovf"},  64'(bus.overflow), 64'(eo));
  endtask

  task automatic do_op(input string nm, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic [W-1:0] es, input logic ec, input logic eo);
    int n;
    issue(av, bv);
    wait_done(n);
    chk({nm, "_latency"}, 64'(n), 64'd9);
    check_result(nm, es, ec, eo);
    // Idle cycle afterwards so that the DONE -> IDLE path is exercised.
    @(posedge clk);
    @(negedge clk);
    chk({nm, "_idle_done"}, 64'(bus.done), 64'd0);
    chk({nm, "_idle_busy"}, 64'(bus.busy), 64'd0);
  endtask

  // ---------------- stimulus ----------------------------------------------
  initial begin
    int n1, n2;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;

    // Check the model itself against hand-computed sums.
    chk("model_pin_1", 64'(model(32'h104A904A, 32'h504A904F)), 64'({2'b00, 32'h60952099}));
    chk("model_pin_2", 64'(model(32'h7FFFFFFF, 32'h00000001)), 64'({2'b10, 32'h80000000}));
    chk("model_pin_3", 64'(model(32'h80000000, 32'h80000000)), 64'({2'b11, 32'h00000000}));

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_sum",   64'(bus.sum),      64'd0);
    chk("reset_carry", 64'(bus.carry),    64'd0);
    chk("reset_ovf",   64'(bus.overflow), 64'd0);
    chk("reset_state", 64'(state_o),      64'd0);
    rst = 1'b0;
    @(negedge clk);

    do_op("t1", 32'h104A904A, 32'h504A904F, 32'h60952099, 1'b0, 1'b0);
    do_op("t2", 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1);
    do_op("t3", 32'h80000000, 32'h80000000, 32'h00000000, 1'b1, 1'b1);
    do_op("t4", 32'hFFFFFDF8, 32'h00000208, 32'h00000000, 1'b1, 1'b0);
    do_op("t_mix", 32'hC0000000, 32'hA0000000, 32'h60000000, 1'b1, 1'b1);

    // A start pulse in the middle of RUN must be ignored. The second request
    // is then issued in the done cycle.
    issue(32'h12345678, 32'h11111111);
    n1 = 0;
    repeat (3) begin
      @(posedge clk);
      n1++;
      @(negedge clk);
      bus.start = 1'b0;
    end
    bus.a     = 32'hFFFFFFFF;
    bus.b     = 32'hFFFFFFFF;
    bus.start = 1'b1;               // not pushed: must be dropped by the DUT
    wait_done(n2);
    chk("t5_latency", 64'(n1 + n2), 64'd9);
    check_result("t5_first", 32'h23456789, 1'b0, 1'b0);
    issue(32'hDEADBEEF, 32'h21524111);
    wait_done(n2);
    chk("t5_b2b_latency", 64'(n2), 64'd9);
    check_result("t5_second", 32'h00000000, 1'b1, 1'b0);

    // Reset while RUN is in progress: all outputs clear at once and no done
    // pulse follows.
    @(negedge clk);
    issue(32'h0F0F0F0F, 32'h01010101);
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
    end
    #2 rst = 1'b1;
    #1;
    chk("t6_busy",  64'(bus.busy),     64'd0);
    chk("t6_done",  64'(bus.done),     64'd0);
    check_result("t6_rst", 32'h00000000, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);     // any spurious done would be flagged
    do_op("t6_fresh", 32'h0F0F0F0F, 32'h01010101, 32'h10101010, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
